// File: rtl/ex_muldiv_pkg.sv
// Shared op codes, state encoding and op-decode helpers for the EX-stage
// multiply/divide unit.
package ex_muldiv_pkg;

  typedef logic [2:0] md_op_t;

  localparam md_op_t MD_OP_NOP   = 3'd0;
  localparam md_op_t MD_OP_MULT  = 3'd1;
  localparam md_op_t MD_OP_MULTU = 3'd2;
  localparam md_op_t MD_OP_DIV   = 3'd3;
  localparam md_op_t MD_OP_DIVU  = 3'd4;

  typedef enum logic [1:0] {
    MD_IDLE    = 2'd0,
    MD_BUSY    = 2'd1,
    MD_DIVZERO = 2'd2,
    MD_DONE    = 2'd3
  } md_state_e;

  function automatic logic md_op_valid(input md_op_t op);
    return (op == MD_OP_MULT) || (op == MD_OP_MULTU) ||
           (op == MD_OP_DIV)  || (op == MD_OP_DIVU);
  endfunction

  function automatic logic md_op_is_div(input md_op_t op);
    return (op == MD_OP_DIV) || (op == MD_OP_DIVU);
  endfunction

  function automatic logic md_op_signed(input md_op_t op);
    return (op == MD_OP_MULT) || (op == MD_OP_DIV);
  endfunction

endpackage

// File: rtl/ex_muldiv_negate.sv
// Conditional two's-complement: y = neg ? (~a + cin) : a. The carry-in lets
// two lanes be chained into one wide negate.
module md_negate #(
  parameter int W = 32
) (
  input  logic         neg_i,
  input  logic         cin_i,
  input  logic [W-1:0] a_i,
  output logic [W-1:0] y_o
);

  logic [W-1:0] inv_sum;

  assign inv_sum = ~a_i + {{(W-1){1'b0}}, cin_i};
  assign y_o     = neg_i ? inv_sum : a_i;

endmodule

// File: rtl/ex_muldiv.sv
// Iterative one-bit-per-cycle multiply (shift-add) and restoring divide with
// a start/ready handshake; HI/LO results are registered on entry to DONE.
module ex_muldiv
  import ex_muldiv_pkg::*;
#(
  parameter  int DATA_W = 32,
  localparam int CNT_W  = $clog2(DATA_W) + 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start_i,
  input  md_op_t            op_i,
  input  logic [DATA_W-1:0] opdata1_i,
  input  logic [DATA_W-1:0] opdata2_i,
  input  logic              annul_i,
  output logic [DATA_W-1:0] hi_o,
  output logic [DATA_W-1:0] lo_o,
  output logic              ready_o,
  output logic              busy_o,
  output logic              stallreq_o
);

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DATA_W);

  md_state_e         state_q, state_d;
  md_op_t            op_q, op_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              sign_q, sign_d, rsign_q, rsign_d;
  logic [DATA_W-1:0] a_q, a_d, acc_hi_q, acc_hi_d, acc_lo_q, acc_lo_d;
  logic [DATA_W-1:0] hi_q, hi_d, lo_q, lo_d;

  // Operand magnitudes: lane 0 is opdata1, lane 1 is opdata2.
  logic              in_signed;
  logic [DATA_W-1:0] opd [2];
  logic [DATA_W-1:0] mag [2];

  assign in_signed = md_op_signed(op_i);
  assign opd[0]    = opdata1_i;
  assign opd[1]    = opdata2_i;

  for (genvar gi = 0; gi < 2; gi++) begin : g_in_mag
    md_negate #(.W(DATA_W)) u_neg (
      .neg_i (in_signed & opd[gi][DATA_W-1]),
      .cin_i (1'b1),
      .a_i   (opd[gi]),
      .y_o   (mag[gi])
    );
  end

  // One iteration step of whichever operation is in flight.
  logic              op_div;
  logic [DATA_W:0]   mul_sum, div_shift;
  logic              div_ge;
  logic [DATA_W-1:0] step_hi, step_lo;

  assign op_div = md_op_is_div(op_q);

  always_comb begin
    mul_sum   = {1'b0, acc_hi_q} + (acc_lo_q[0] ? {1'b0, a_q} : '0);
    div_shift = {acc_hi_q, acc_lo_q[DATA_W-1]};
    div_ge    = (div_shift >= {1'b0, a_q});
    if (op_div) begin
      step_hi = div_ge ? DATA_W'(div_shift - {1'b0, a_q}) : div_shift[DATA_W-1:0];
      step_lo = {acc_lo_q[DATA_W-2:0], div_ge};
    end else begin
      step_hi = mul_sum[DATA_W:1];
      step_lo = {mul_sum[0], acc_lo_q[DATA_W-1:1]};
    end
  end

  // Sign fix-up: for a product the two lanes chain into one 2*DATA_W negate
  // (high lane's +1 only when the low half is zero); for a divide they are
  // independent negates of quotient and remainder.
  logic [DATA_W-1:0] res_raw [2];
  logic [DATA_W-1:0] res     [2];
  logic [1:0]        res_neg, res_cin;

  assign res_raw[0] = step_lo;
  assign res_raw[1] = step_hi;
  assign res_neg    = {op_div ? rsign_q : sign_q, sign_q};
  assign res_cin    = {op_div ? 1'b1 : ~|step_lo, 1'b1};

  for (genvar gi = 0; gi < 2; gi++) begin : g_res_fix
    md_negate #(.W(DATA_W)) u_neg (
      .neg_i (res_neg[gi]),
      .cin_i (res_cin[gi]),
      .a_i   (res_raw[gi]),
      .y_o   (res[gi])
    );
  end

  always_comb begin
    state_d  = state_q;
    op_d     = op_q;
    cnt_d    = cnt_q;
    sign_d   = sign_q;
    rsign_d  = rsign_q;
    a_d      = a_q;
    acc_hi_d = acc_hi_q;
    acc_lo_d = acc_lo_q;
    hi_d     = hi_q;
    lo_d     = lo_q;
    unique case (state_q)
      MD_IDLE: begin
        if (start_i && !annul_i && md_op_valid(op_i)) begin
          op_d     = op_i;
          sign_d   = in_signed & (opdata1_i[DATA_W-1] ^ opdata2_i[DATA_W-1]);
          rsign_d  = in_signed & opdata1_i[DATA_W-1];
          cnt_d    = '0;
          acc_hi_d = '0;
          if (md_op_is_div(op_i)) begin
            a_d      = mag[1];
            acc_lo_d = mag[0];
            state_d  = (opdata2_i == '0) ? MD_DIVZERO : MD_BUSY;
          end else begin
            a_d      = mag[0];
            acc_lo_d = mag[1];
            state_d  = MD_BUSY;
          end
        end
      end
      MD_BUSY: begin
        if (annul_i || !start_i) begin
          state_d = MD_IDLE;
        end else begin
          acc_hi_d = step_hi;
          acc_lo_d = step_lo;
          cnt_d    = cnt_q + CNT_W'(1);
          if (cnt_d == CNT_LAST) begin
            hi_d    = res[1];
            lo_d    = res[0];
            state_d = MD_DONE;
          end
        end
      end
      MD_DIVZERO: begin
        if (annul_i || !start_i) begin
          state_d = MD_IDLE;
        end else begin
          hi_d    = '0;
          lo_d    = '0;
          state_d = MD_DONE;
        end
      end
      MD_DONE: begin
        if (annul_i || !start_i) state_d = MD_IDLE;
      end
      default: state_d = MD_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= MD_IDLE;
      op_q     <= MD_OP_NOP;
      cnt_q    <= '0;
      sign_q   <= 1'b0;
      rsign_q  <= 1'b0;
      a_q      <= '0;
      acc_hi_q <= '0;
      acc_lo_q <= '0;
      hi_q     <= '0;
      lo_q     <= '0;
    end else begin
      state_q  <= state_d;
      op_q     <= op_d;
      cnt_q    <= cnt_d;
      sign_q   <= sign_d;
      rsign_q  <= rsign_d;
      a_q      <= a_d;
      acc_hi_q <= acc_hi_d;
      acc_lo_q <= acc_lo_d;
      hi_q     <= hi_d;
      lo_q     <= lo_d;
    end
  end

  assign hi_o       = hi_q;
  assign lo_o       = lo_q;
  assign ready_o    = (state_q == MD_DONE);
  assign busy_o     = (state_q == MD_BUSY) || (state_q == MD_DIVZERO);
  assign stallreq_o = start_i & ~ready_o & md_op_valid(op_i);

endmodule
